spi_reg_ctrl: RTL and testbench

- Frame-level controller placed behind the SPI slave byte engine.
- Consumes received bytes (rxd_out/rxd_flag) and the raw chip-select line.
- Decodes a command byte, then sequences burst register writes or reads on a simple local register bus with auto-incrementing address.
- Supplies the next transmit byte (txd_data) to the byte engine for read-back on MISO.

---
 rtl/spi_reg_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_spi_reg_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: frame-level controller placed behind an SPI slave byte engine.
// The first byte of a frame is a command: bit 7 selects read (1) or write (0),
// and the low ADDR_W bits give the start address. The following bytes are a
// burst of data with an auto-incrementing address on a simple register bus.
// Optional build macro SPI_STATUS_BYTE_EN: while the command byte is being
// received, txd_data carries {burst_err, 4'b0, frame_cnt[2:0]} instead of IDLE_TX.
module spi_reg_ctrl #(
    parameter int         ADDR_W    = 7,
    parameter logic [7:0] IDLE_TX   = 8'hFF,
    parameter int         MAX_BURST = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cs,
    input  logic [7:0]        rxd_out,
    input  logic              rxd_flag,
    output logic [7:0]        txd_data,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_wr,
    output logic              reg_rd,
    input  logic [7:0]        reg_rdata,
    output logic              busy,
    output logic              frame_done,
    output logic              burst_err
);

    typedef enum logic [2:0] {
        WAIT_CS = 3'd0,
        IDLE    = 3'd1,
        CMD     = 3'd2,
        WDATA   = 3'd3,
        RDATA   = 3'd4
    } state_e;

    localparam logic [15:0]       BURST_LIM = 16'(MAX_BURST);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1'b1);

    state_e            state_q;
    logic              cs_meta_q;
    logic              cs_s_q;
    logic              cs_prev_q;
    logic              wr_pend_q;
    logic              rd_pend_q;
    logic              data_seen_q;
    logic [15:0]       burst_cnt_q;
    logic [7:0]        txd_data_q;
    logic [ADDR_W-1:0] reg_addr_q;
    logic [7:0]        reg_wdata_q;
    logic              reg_wr_q;
    logic              reg_rd_q;
    logic              busy_q;
    logic              frame_done_q;
    logic              burst_err_q;

    logic              cs_fall;
    logic              cs_rise;
    logic              burst_full;
    logic              data_accept;
    logic [7:0]        cmd_tx;

    assign cs_fall     = cs_prev_q & ~cs_s_q;
    assign cs_rise     = ~cs_prev_q & cs_s_q;
    // A limit of zero means the burst is never full.
    assign burst_full  = (BURST_LIM != 16'd0) && (burst_cnt_q >= BURST_LIM);
    assign data_accept = rxd_flag && ((state_q == WDATA) || (state_q == RDATA)) && !burst_full;

`ifdef SPI_STATUS_BYTE_EN
    logic [2:0] frame_cnt_q;

    // The status byte reports the previous frame's error before it is cleared.
    assign cmd_tx = {burst_err_q, 4'b0000, frame_cnt_q};

    // Count completed frames (mod 8) alongside each frame_done pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_cnt_q <= 3'd0;
        end else if (cs_rise && (data_seen_q || data_accept)) begin
            frame_cnt_q <= frame_cnt_q + 3'd1;
        end else begin
            frame_cnt_q <= frame_cnt_q;
        end
    end
`else
    assign cmd_tx = IDLE_TX;
`endif

    // Two-flop synchroniser for cs plus a delayed copy for edge detection.
    // Reset to "selected" so a frame already running at reset is never joined.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cs_meta_q <= 1'b0;
            cs_s_q    <= 1'b0;
            cs_prev_q <= 1'b0;
        end else begin
            cs_meta_q <= cs;
            cs_s_q    <= cs_meta_q;
            cs_prev_q <= cs_s_q;
        end
    end

    // Frame sequencer: command decode, burst data handling and bus strobes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= WAIT_CS;
            wr_pend_q    <= 1'b0;
            rd_pend_q    <= 1'b0;
            data_seen_q  <= 1'b0;
            burst_cnt_q  <= 16'd0;
            txd_data_q   <= IDLE_TX;
            reg_addr_q   <= '0;
            reg_wdata_q  <= 8'h00;
            reg_wr_q     <= 1'b0;
            reg_rd_q     <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            burst_err_q  <= 1'b0;
        end else begin
            // Strobes trail their request by one cycle and last one cycle.
            wr_pend_q    <= 1'b0;
            rd_pend_q    <= 1'b0;
            reg_wr_q     <= wr_pend_q;
            reg_rd_q     <= rd_pend_q;
            frame_done_q <= 1'b0;

            // Address advances only after the write strobe has used it.
            if (reg_wr_q) begin
                reg_addr_q <= reg_addr_q + ADDR_ONE;
            end

            // Read data is captured the cycle after the read strobe, but only
            // while the read burst is still open.
            if (reg_rd_q) begin
                txd_data_q <= (state_q == RDATA) ? reg_rdata : IDLE_TX;
            end

            case (state_q)
                WAIT_CS: begin
                    if (cs_s_q) begin
                        state_q <= IDLE;
                    end
                end
                IDLE: begin
                    if (cs_fall) begin
                        state_q     <= CMD;
                        busy_q      <= 1'b1;
                        burst_err_q <= 1'b0;
                        burst_cnt_q <= 16'd0;
                        data_seen_q <= 1'b0;
                        txd_data_q  <= cmd_tx;
                    end
                end
                CMD: begin
                    if (rxd_flag) begin
                        reg_addr_q <= rxd_out[ADDR_W-1:0];
                        txd_data_q <= IDLE_TX;
                        if (rxd_out[7]) begin
                            state_q   <= RDATA;
                            rd_pend_q <= 1'b1;
                        end else begin
                            state_q <= WDATA;
                        end
                    end
                end
                WDATA: begin
                    if (rxd_flag) begin
                        if (!burst_full) begin
                            reg_wdata_q <= rxd_out;
                            wr_pend_q   <= 1'b1;
                            data_seen_q <= 1'b1;
                            if (BURST_LIM != 16'd0) begin
                                burst_cnt_q <= burst_cnt_q + 16'd1;
                            end
                        end else begin
                            burst_err_q <= 1'b1;
                        end
                    end
                end
                RDATA: begin
                    if (rxd_flag) begin
                        if (!burst_full) begin
                            reg_addr_q  <= reg_addr_q + ADDR_ONE;
                            rd_pend_q   <= 1'b1;
                            data_seen_q <= 1'b1;
                            if (BURST_LIM != 16'd0) begin
                                burst_cnt_q <= burst_cnt_q + 16'd1;
                            end
                        end else begin
                            burst_err_q <= 1'b1;
                            txd_data_q  <= IDLE_TX;
                        end
                    end
                end
                default: begin
                    state_q <= WAIT_CS;
                end
            endcase

            // End of frame wins over the state update above; a byte flagged in
            // the same cycle has already queued its strobe and still counts.
            if (cs_rise) begin
                state_q      <= IDLE;
                busy_q       <= 1'b0;
                txd_data_q   <= IDLE_TX;
                data_seen_q  <= 1'b0;
                frame_done_q <= data_seen_q || data_accept;
            end
        end
    end

    assign txd_data   = txd_data_q;
    assign reg_addr   = reg_addr_q;
    assign reg_wdata  = reg_wdata_q;
    assign reg_wr     = reg_wr_q;
    assign reg_rd     = reg_rd_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign burst_err  = burst_err_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Testbench for spi_reg_ctrl: two instances (unlimited burst and MAX_BURST=2)
// driven with identical frames; a frame-level model predicts bus traffic,
// MISO bytes, frame_done and burst_err for each.
`timescale 1ns/1ps
module tb_spi_reg_ctrl;
    localparam int AW    = 7;
    localparam int LIM_B = 2;

    logic          clk = 1'b0;
    logic          rstn;
    logic          cs;
    logic [7:0]    rxd_out;
    logic          rxd_flag;

    logic [7:0]    txd_a, wdata_a, rdata_a, txd_b, wdata_b, rdata_b;
    logic [AW-1:0] addr_a, addr_b;
    logic          wr_a, rd_a, busy_a, done_a, err_a;
    logic          wr_b, rd_b, busy_b, done_b, err_b;

    // Register model: read data is the address with bit 7 set.
    assign rdata_a = {1'b0, addr_a} ^ 8'h80;
    assign rdata_b = {1'b0, addr_b} ^ 8'h80;

    spi_reg_ctrl #(.ADDR_W(AW), .IDLE_TX(8'hFF), .MAX_BURST(0)) dut_a (
        .clk(clk), .rstn(rstn), .cs(cs), .rxd_out(rxd_out), .rxd_flag(rxd_flag),
        .txd_data(txd_a), .reg_addr(addr_a), .reg_wdata(wdata_a), .reg_wr(wr_a),
        .reg_rd(rd_a), .reg_rdata(rdata_a), .busy(busy_a), .frame_done(done_a),
        .burst_err(err_a));

    spi_reg_ctrl #(.ADDR_W(AW), .IDLE_TX(8'hFF), .MAX_BURST(LIM_B)) dut_b (
        .clk(clk), .rstn(rstn), .cs(cs), .rxd_out(rxd_out), .rxd_flag(rxd_flag),
        .txd_data(txd_b), .reg_addr(addr_b), .reg_wdata(wdata_b), .reg_wr(wr_b),
        .reg_rd(rd_b), .reg_rdata(rdata_b), .busy(busy_b), .frame_done(done_b),
        .burst_err(err_b));

    always #5 clk = ~clk;

    typedef struct packed {
        logic       wr;
        logic [6:0] addr;
        logic [7:0] data;
    } ev_t;

    ev_t got_a[$], got_b[$], exp_a[$], exp_b[$];
    int  done_cnt_a = 0, done_cnt_b = 0, clash_cnt = 0;
    int  checks = 0, errors = 0;

    bit         err_m  [2];
    logic [2:0] fcnt_m [2];
    int         lim    [2];
    int         last_ev_a, last_ev_b, last_done_a;
    logic       last_err_b;

    // Bus monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (wr_a) got_a.push_back({1'b1, addr_a, wdata_a});
        if (rd_a) got_a.push_back({1'b0, addr_a, 8'h00});
        if (wr_b) got_b.push_back({1'b1, addr_b, wdata_b});
        if (rd_b) got_b.push_back({1'b0, addr_b, 8'h00});
        if ((wr_a && rd_a) || (wr_b && rd_b)) clash_cnt++;
        if (done_a) done_cnt_a++;
        if (done_b) done_cnt_b++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_byte(input logic [7:0] b);
        rxd_out  = b;
        rxd_flag = 1'b1;
        @(negedge clk);
        rxd_flag = 1'b0;
    endtask

    task automatic compare_events();
        check("ev_count_a", got_a.size(), exp_a.size());
        for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) check("ev_a", got_a[i], exp_a[i]);
        check("ev_count_b", got_b.size(), exp_b.size());
        for (int i = 0; i < got_b.size() && i < exp_b.size(); i++) check("ev_b", got_b[i], exp_b[i]);
    endtask

    task automatic clear_events();
        got_a.delete(); got_b.delete(); exp_a.delete(); exp_b.delete();
    endtask

    task automatic check_reset_values();
        check("rst_txd", {txd_a, txd_b}, 16'hFFFF);
        check("rst_addr", {addr_a, addr_b}, 14'h0);
        check("rst_wdata", {wdata_a, wdata_b}, 16'h0);
        check("rst_strobes", {wr_a, rd_a, wr_b, rd_b}, 4'h0);
        check("rst_flags", {busy_a, done_a, err_a, busy_b, done_b, err_b}, 6'h0);
    endtask

    // One complete frame: command, n data bytes, then cs release.
    task automatic run_frame(input logic [7:0] cmd, input int n, input logic [31:0] dat);
        logic [6:0] a;
        bit         rd;
        int         acc [2];
        int         da, db;
        logic [7:0] st  [2];
        logic [7:0] exp_tx;
        ev_t        e;
        a  = cmd[6:0];
        rd = cmd[7];
        clear_events();
        for (int k = 0; k < 2; k++) begin
            acc[k] = (lim[k] == 0 || n <= lim[k]) ? n : lim[k];
`ifdef SPI_STATUS_BYTE_EN
            st[k] = {err_m[k], 4'b0000, fcnt_m[k]};
`else
            st[k] = 8'hFF;
`endif
        end
        if (rd) begin
            exp_a.push_back({1'b0, a, 8'h00});
            exp_b.push_back({1'b0, a, 8'h00});
        end
        for (int i = 0; i < n; i++) begin
            e = rd ? {1'b0, 7'(a + 1 + i), 8'h00} : {1'b1, 7'(a + i), dat[8*i +: 8]};
            if (i < acc[0]) exp_a.push_back(e);
            if (i < acc[1]) exp_b.push_back(e);
        end

        cs = 1'b0;
        tick(6);
        check("cmd_tx_a", txd_a, st[0]);
        check("cmd_tx_b", txd_b, st[1]);
        check("busy", {busy_a, busy_b}, 2'b11);
        pulse_byte(cmd);
        tick(3);
        exp_tx = rd ? ({1'b0, a} ^ 8'h80) : 8'hFF;
        check("first_tx_a", txd_a, exp_tx);
        check("first_tx_b", txd_b, exp_tx);
        for (int i = 0; i < n; i++) begin
            tick(12);
            pulse_byte(dat[8*i +: 8]);
            tick(3);
            exp_tx = (rd && i < acc[0]) ? ({1'b0, 7'(a + 1 + i)} ^ 8'h80) : 8'hFF;
            check("data_tx_a", txd_a, exp_tx);
            exp_tx = (rd && i < acc[1]) ? ({1'b0, 7'(a + 1 + i)} ^ 8'h80) : 8'hFF;
            check("data_tx_b", txd_b, exp_tx);
        end
        tick(6);
        da = done_cnt_a;
        db = done_cnt_b;
        cs = 1'b1;
        tick(10);
        last_done_a = done_cnt_a - da;
        last_ev_a   = got_a.size();
        last_ev_b   = got_b.size();
        last_err_b  = err_b;
        check("done_a", done_cnt_a - da, (acc[0] > 0) ? 1 : 0);
        check("done_b", done_cnt_b - db, (acc[1] > 0) ? 1 : 0);
        check("err_a", err_a, 1'b0);
        check("err_b", err_b, (lim[1] != 0 && n > lim[1]) ? 1 : 0);
        check("end_tx", {txd_a, txd_b}, 16'hFFFF);
        check("end_busy", {busy_a, busy_b}, 2'b00);
        compare_events();
        for (int k = 0; k < 2; k++) begin
            err_m[k] = (lim[k] != 0 && n > lim[k]);
            if (acc[k] > 0) fcnt_m[k] = fcnt_m[k] + 3'd1;
        end
    endtask

    typedef struct {
        logic [7:0]  cmd;
        int          n;
        logic [31:0] dat;
        int          exp_ev_a;
        int          exp_ev_b;
        logic        exp_err_b;
        int          exp_done;
    } vec_t;

    vec_t vecs [6];

    initial begin
        lim[0] = 0;    lim[1] = LIM_B;
        err_m[0] = 0;  err_m[1] = 0;
        fcnt_m[0] = 3'd0; fcnt_m[1] = 3'd0;

        vecs[0] = '{8'h05, 3, 32'h00332211, 3, 2, 1'b1, 1};  // write burst, B over limit
        vecs[1] = '{8'h82, 2, 32'h00000000, 3, 3, 1'b0, 1};  // read burst 0x02..0x04
        vecs[2] = '{8'h7F, 2, 32'h0000BBAA, 2, 2, 1'b0, 1};  // address wrap 7F -> 00
        vecs[3] = '{8'h10, 0, 32'h00000000, 0, 0, 1'b0, 0};  // command-only write
        vecs[4] = '{8'hFF, 3, 32'h00000000, 4, 3, 1'b1, 1};  // read wrap, B over limit
        vecs[5] = '{8'h00, 1, 32'h000000C3, 1, 1, 1'b0, 1};  // single write

        rstn = 1'b0; cs = 1'b1; rxd_out = 8'h00; rxd_flag = 1'b0;
        tick(3);
        check_reset_values();
        rstn = 1'b1;
        tick(6);

        // Directed table.
        for (int v = 0; v < 6; v++) begin
            run_frame(vecs[v].cmd, vecs[v].n, vecs[v].dat);
            check("tbl_ev_a", last_ev_a, vecs[v].exp_ev_a);
            check("tbl_ev_b", last_ev_b, vecs[v].exp_ev_b);
            check("tbl_err_b", last_err_b, vecs[v].exp_err_b);
            check("tbl_done", last_done_a, vecs[v].exp_done);
        end

        // Byte flag coincides with the synchronised cs rise: byte still written.
        clear_events();
        cs = 1'b0; tick(6);
        pulse_byte(8'h30); tick(12);
        begin
            int da;
            da = done_cnt_a;
            cs = 1'b1;
            tick(2);
            pulse_byte(8'h5A);
            tick(8);
            exp_a.push_back({1'b1, 7'h30, 8'h5A});
            exp_b.push_back({1'b1, 7'h30, 8'h5A});
            compare_events();
            check("coincide_done", done_cnt_a - da, 1);
            check("coincide_tx", txd_a, 8'hFF);
        end
        for (int k = 0; k < 2; k++) begin err_m[k] = 0; fcnt_m[k] = fcnt_m[k] + 3'd1; end

        // Abort during first data byte: no strobe, no frame_done.
        clear_events();
        begin
            int da;
            da = done_cnt_a;
            cs = 1'b0; tick(6);
            pulse_byte(8'h40); tick(4);
            cs = 1'b1; tick(10);
            compare_events();
            check("abort_done", done_cnt_a - da, 0);
            check("abort_busy", busy_a, 1'b0);
            check("abort_tx", txd_a, 8'hFF);
        end
        for (int k = 0; k < 2; k++) err_m[k] = 0;
        run_frame(8'h41, 1, 32'h00000077);

        // Reset in the middle of a write burst with cs held low.
        clear_events();
        cs = 1'b0; tick(6);
        pulse_byte(8'h20); tick(12);
        pulse_byte(8'h01); tick(6);
        exp_a.push_back({1'b1, 7'h20, 8'h01});
        exp_b.push_back({1'b1, 7'h20, 8'h01});
        compare_events();
        rstn = 1'b0; tick(2);
        rstn = 1'b1; tick(4);
        check_reset_values();
        clear_events();
        begin
            int da;
            da = done_cnt_a;
            pulse_byte(8'h02); tick(12);
            pulse_byte(8'h03); tick(6);
            cs = 1'b1; tick(10);
            compare_events();
            check("rst_no_done", done_cnt_a - da, 0);
        end
        for (int k = 0; k < 2; k++) begin err_m[k] = 0; fcnt_m[k] = 3'd0; end
        run_frame(8'h21, 2, 32'h0000BEEF);

        // Randomised frames against the model.
        for (int r = 0; r < 24; r++) begin
            logic [7:0] c;
            int         nb;
            c  = 8'($urandom_range(0, 255));
            nb = c[7] ? $urandom_range(1, 4) : $urandom_range(0, 4);
            run_frame(c, nb, $urandom);
        end

        check("no_wr_rd_clash", clash_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
